sys_mem: RTL and testbench
==========================

Name: sys_mem

Overview:
- Byte-wide, single-port, word-addressed RAM that serves as main memory for the 6502 core.
- Connects to the core's split data bus: din carries write data, dout carries read data.
- Provides a whole-array bulk-load port, used by the bench to preload firmware and random fill.
- Provides a continuous flat monitor port, used by the bench for dumps and scoreboarding.

Parameters:
- DEPTH, default 256: number of byte locations; valid addresses are 0 to DEPTH-1.
- WIDTH, default 8: data width in bits; equals REG_WIDTH.
- ADDR_WIDTH, default 16: address bus width in bits; matches the CPU address bus.

Ports:
- clk  in  1: single clock; every state change happens on its rising edge.
- reset  in  1: synchronous, active-high reset.
- we  in  1: write enable; the system drives it from the inverse of R_W_n.
- din  in  WIDTH: write data.
- addr  in  ADDR_WIDTH: byte address for both read and write.
- dout  out  WIDTH: read data.
- override_mem  in  1: bulk-load strobe.
- mem_override_in  in  DEPTH*WIDTH: flat image for bulk load; location i is bits [WIDTH*i+WIDTH-1 : WIDTH*i].
- mem_monitor  out  DEPTH*WIDTH: flat live copy of the array, using the same packing as mem_override_in.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Storage is an array of DEPTH words of WIDTH bits.
- Read path:
  - Asynchronous (combinational), zero cycles of latency: dout = mem[addr].
  - If addr >= DEPTH, dout = 0.
- Write path, evaluated at rising clk, first matching rule wins:
  1. If reset = 1, all locations become 0.
  2. Else if override_mem = 1, location i takes slice i of mem_override_in, for every i.
  3. Else if we = 1 and addr < DEPTH, mem[addr] takes din.
  4. Else the array holds.
- Simultaneous events:
  - reset together with override_mem or we: reset wins.
  - override_mem together with we: override wins and din is discarded.
- Writes to addr >= DEPTH are ignored. There is no wrap-around or aliasing.
- Read-after-write:
  - Before the edge, dout shows the old contents.
  - After the edge, dout combinationally shows the newly written value.
  - No bypass or forwarding is needed.
- mem_monitor is driven combinationally from the array at all times, including during reset.
- Reset values:
  - The array is undefined until the first reset edge.
  - After reset, the array is all 0, dout = 0, and mem_monitor = 0.
- Reset applied mid-operation clears everything on that edge, regardless of we or override_mem.
- override_mem may be held high for several cycles; the array reloads on every edge while it is high.
- There is no handshake and no busy or valid signal. The CPU samples dout on its own phase.

Decomposition:
- Shared package holds:
  - REG_WIDTH = 8, ADDR_WIDTH = 16, MEM_DEPTH, INSTRUCTION_BASE.
  - A register typedef of logic [REG_WIDTH-1:0].
- The package is used by the CPU, this memory and the bench.
- Pack and unpack of the flat ports use generate loops inside the module; no sub-module.
- Flat ports remain in synthesis builds but are tied off (override_mem = 0) outside simulation.

Test Plan:
- Reset 1 cycle with we = 1, addr = 0x0010, din = 0xAA → all of mem_monitor = 0; dout at 0x0010 = 0x00.
- After reset, we = 1, addr = 0x0005, din = 0x3C for one edge, then we = 0 → dout = 0x3C immediately after the edge; mem_monitor bits [47:40] = 0x3C; neighbouring locations remain 0.
- override_mem = 1 for one edge with image[i] = i XOR 0x5A → mem_monitor equals the image; reading addr 0x0003 gives 0x59.
- override_mem = 1 and we = 1 (addr 0x0003, din 0xFF) on the same edge → location 3 = image value 0x59, not 0xFF.
- reset = 1 and override_mem = 1 on the same edge → array all 0.
- DEPTH = 256: write addr 0x0100 with din 0x77 → no location changes; dout at 0x0100 = 0x00; dout at 0x0000 is unchanged.

Source files
------------

// File: rtl/sys_mem_pkg.sv
// Shared system constants and types for the 6502 core, its main memory and the bench.
package sys_mem_pkg;

    localparam int REG_WIDTH        = 8;
    localparam int ADDR_WIDTH       = 16;
    localparam int MEM_DEPTH        = 256;
    localparam int INSTRUCTION_BASE = 16'h0080;

    typedef logic [REG_WIDTH-1:0] reg_t;

endpackage

// File: rtl/sys_mem.sv
// Byte-wide, single-port, word-addressed main memory for the 6502 core.
// Combinational read, clocked write, whole-array bulk load and a flat live
// monitor of the array. Out-of-range addresses read as zero and never write.
// In synthesis builds the flat ports stay present but override_mem is tied
// low by the system, so only the CPU write path remains active.
module sys_mem
    import sys_mem_pkg::*;
#(
    parameter int DEPTH      = MEM_DEPTH,
    parameter int WIDTH      = REG_WIDTH,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   we,
    input  logic [WIDTH-1:0]       din,
    input  logic [ADDR_WIDTH-1:0]  addr,
    output logic [WIDTH-1:0]       dout,
    input  logic                   override_mem,
    input  logic [DEPTH*WIDTH-1:0] mem_override_in,
    output logic [DEPTH*WIDTH-1:0] mem_monitor
);

    // Index width for the in-range part of the address.
    localparam int IDX_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Live view of every location, fed from the per-location registers below.
    logic [WIDTH-1:0] mem_q [DEPTH];

    // High when the CPU address lands inside the array; no aliasing above DEPTH.
    logic addr_in_range;
    assign addr_in_range = (32'(addr) < 32'(DEPTH));

    // Each location is its own register so that reset and bulk load can touch
    // the whole array on a single edge. Priority: reset, bulk load, CPU write.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cell
            logic [WIDTH-1:0] cell_reg;
            logic             cell_sel;

            // CPU write decode: full-width compare so addresses >= DEPTH never match.
            assign cell_sel = we && (addr == ADDR_WIDTH'(gi));

            // Location update with reset > override > write > hold.
            always_ff @(posedge clk) begin
                if (reset) begin
                    cell_reg <= '0;
                end else if (override_mem) begin
                    cell_reg <= mem_override_in[WIDTH*gi +: WIDTH];
                end else if (cell_sel) begin
                    cell_reg <= din;
                end
            end

            assign mem_q[gi]                        = cell_reg;
            assign mem_monitor[WIDTH*gi +: WIDTH]   = cell_reg;
        end
    endgenerate

    // Asynchronous read: a write shows up on dout right after its edge, no bypass.
    always_comb begin
        dout = '0;
        if (addr_in_range) begin
            dout = mem_q[addr[IDX_WIDTH-1:0]];
        end
    end

endmodule

// File: tb/tb_sys_mem.sv
// Directed, table-driven bench for sys_mem plus short hand-written sequences
// for read-after-write timing and a held bulk-load strobe.
module tb_sys_mem;
    import sys_mem_pkg::*;

    localparam int DEPTH = MEM_DEPTH;
    localparam int WIDTH = REG_WIDTH;
    localparam int AW    = 16;

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    logic                   we = 1'b0;
    logic [WIDTH-1:0]       din = '0;
    logic [AW-1:0]          addr = '0;
    logic [WIDTH-1:0]       dout;
    logic                   override_mem = 1'b0;
    logic [DEPTH*WIDTH-1:0] mem_override_in = '0;
    logic [DEPTH*WIDTH-1:0] mem_monitor;

    logic [DEPTH*WIDTH-1:0] img_a;
    logic [DEPTH*WIDTH-1:0] img_b;
    logic [DEPTH*WIDTH-1:0] img_zero;

    int total = 0;
    int bad   = 0;

    sys_mem #(
        .DEPTH      (DEPTH),
        .WIDTH      (WIDTH),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .we              (we),
        .din             (din),
        .addr            (addr),
        .dout            (dout),
        .override_mem    (override_mem),
        .mem_override_in (mem_override_in),
        .mem_monitor     (mem_monitor)
    );

    always #5 clk = ~clk;

    // full: 0 = no whole-array check, 1 = expect all zero, 2 = expect img_a
    typedef struct {
        string       name;
        logic        rst;
        logic        wr;
        logic        ovr;
        logic [15:0] a;
        logic [7:0]  d;
        logic [15:0] chk;
        logic [7:0]  exp;
        int          full;
    } vec_t;

    vec_t vecs [12];

    task automatic check8(input string nm, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%02h expected=%02h", nm, got, exp);
        end else begin
            $display("ok   %s value=%02h", nm, got);
        end
    endtask

    task automatic check_full(input string nm, input logic [DEPTH*WIDTH-1:0] exp);
        int first;
        first = -1;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (mem_monitor[WIDTH*i +: WIDTH] !== exp[WIDTH*i +: WIDTH]) first = i;
        end
        total++;
        if (first >= 0) begin
            bad++;
            $display("FAIL %s first bad location %0d got=%02h expected=%02h", nm, first,
                     mem_monitor[WIDTH*first +: WIDTH], exp[WIDTH*first +: WIDTH]);
        end else begin
            $display("ok   %s whole array matches", nm);
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            img_a[WIDTH*i +: WIDTH] = 8'(i) ^ 8'h5A;
            img_b[WIDTH*i +: WIDTH] = 8'(i) ^ 8'hA5;
        end
        img_zero = '0;
        mem_override_in = img_a;

        //           name         rst   we    ovr   addr      din    chk       exp    full
        vecs[0]  = '{"rst_we",    1'b1, 1'b1, 1'b0, 16'h0010, 8'hAA, 16'h0010, 8'h00, 1};
        vecs[1]  = '{"wr_05",     1'b0, 1'b1, 1'b0, 16'h0005, 8'h3C, 16'h0005, 8'h3C, 0};
        vecs[2]  = '{"nbr_04",    1'b0, 1'b0, 1'b0, 16'h0004, 8'h00, 16'h0004, 8'h00, 0};
        vecs[3]  = '{"nbr_06",    1'b0, 1'b0, 1'b0, 16'h0006, 8'h00, 16'h0006, 8'h00, 0};
        vecs[4]  = '{"ovr_img",   1'b0, 1'b0, 1'b1, 16'h0003, 8'h00, 16'h0003, 8'h59, 2};
        vecs[5]  = '{"ovr_vs_we", 1'b0, 1'b1, 1'b1, 16'h0003, 8'hFF, 16'h0003, 8'h59, 2};
        vecs[6]  = '{"wr_oob",    1'b0, 1'b1, 1'b0, 16'h0100, 8'h77, 16'h0100, 8'h00, 2};
        vecs[7]  = '{"rd_00",     1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 16'h0000, 8'h5A, 0};
        vecs[8]  = '{"wr_top",    1'b0, 1'b1, 1'b0, 16'h00FF, 8'h11, 16'h00FF, 8'h11, 0};
        vecs[9]  = '{"rst_ovr",   1'b1, 1'b0, 1'b1, 16'h0003, 8'h00, 16'h0003, 8'h00, 1};
        vecs[10] = '{"wr_80",     1'b0, 1'b1, 1'b0, 16'h0080, 8'hC3, 16'h0080, 8'hC3, 0};
        vecs[11] = '{"we_low",    1'b0, 1'b0, 1'b0, 16'h0080, 8'h99, 16'h0080, 8'hC3, 0};

        // Table: drive on the falling edge, let one rising edge act, then look.
        for (int v = 0; v < 12; v++) begin
            @(negedge clk);
            reset        = vecs[v].rst;
            we           = vecs[v].wr;
            override_mem = vecs[v].ovr;
            addr         = vecs[v].a;
            din          = vecs[v].d;
            @(posedge clk);
            #1;
            reset        = 1'b0;
            we           = 1'b0;
            override_mem = 1'b0;
            addr         = vecs[v].chk;
            #1;
            check8({vecs[v].name, "_dout"}, dout, vecs[v].exp);
            if (vecs[v].chk < 16'(DEPTH)) begin
                check8({vecs[v].name, "_mon"}, mem_monitor[WIDTH*int'(vecs[v].chk) +: WIDTH],
                       vecs[v].exp);
            end
            if (vecs[v].full == 1) check_full({vecs[v].name, "_all"}, img_zero);
            if (vecs[v].full == 2) check_full({vecs[v].name, "_all"}, img_a);
        end

        // Read-after-write: old value before the edge, new value right after it.
        @(negedge clk);
        we   = 1'b1;
        addr = 16'h0005;
        din  = 8'h42;
        #1;
        check8("raw_before", dout, 8'h00);
        @(posedge clk);
        #1;
        check8("raw_after", dout, 8'h42);
        we = 1'b0;

        // Held bulk load: array follows the image on every edge while strobed.
        @(negedge clk);
        override_mem    = 1'b1;
        mem_override_in = img_a;
        @(posedge clk);
        #1;
        check_full("hold_ovr_a", img_a);
        @(negedge clk);
        mem_override_in = img_b;
        @(posedge clk);
        #1;
        check_full("hold_ovr_b", img_b);
        override_mem = 1'b0;
        addr         = 16'h0003;
        #1;
        check8("hold_ovr_rd3", dout, 8'hA6);

        // Out-of-range read far above the array reads zero.
        addr = 16'hFFFF;
        #1;
        check8("rd_ffff", dout, 8'h00);

        // Reset mid-operation with a write pending clears everything.
        @(negedge clk);
        reset = 1'b1;
        we    = 1'b1;
        addr  = 16'h0007;
        din   = 8'hEE;
        @(posedge clk);
        #1;
        reset = 1'b0;
        we    = 1'b0;
        #1;
        check8("rst_mid_rd7", dout, 8'h00);
        check_full("rst_mid_all", img_zero);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
